// File: rtl/ecc_pkg.sv
// Shared definitions for the GF(2^m) datapath blocks.
// Holds the default field-element width and the holding-slot state encoding.
// No logic; imported by deselect and hold_slot.
package ecc_pkg;

  // Field-element width for GF(2^233)
  localparam int ECC_N = 233;

  // Occupancy of a single-element holding slot
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage : ecc_pkg

// File: rtl/hold_slot.sv
// One-element output holding register with valid/ready handshake.
// Latency: element loaded on an edge is presented on dout the following cycle.
// Backpressure: a FULL slot holds data/valid while ready=0; drain+load on one edge stays FULL.
// Ports:
//   CLK, RST     - clock, async active-high reset (slot EMPTY, dout=0)
//   load, din    - write din into the slot this edge (caller guarantees space)
//   valid, ready - downstream handshake; valid is 1 exactly when FULL
//   dout         - slot contents (keeps last value after draining)
module hold_slot
  import ecc_pkg::*;
#(
  parameter int N = ECC_N
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] dout
);

  slot_state_t  r_state;
  logic [N-1:0] r_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else begin
      if (load) begin
        // A load wins over a drain: the slot stays FULL with the new element
        r_data  <= din;
        r_state <= FULL;
      end else if (valid && ready) begin
        // Data register intentionally left untouched on drain
        r_state <= EMPTY;
      end
    end
  end

  assign valid = (r_state == FULL);
  assign dout  = r_data;

endmodule : hold_slot

// File: rtl/deselect.sv
// 1-to-2 demultiplexer routing field elements to destination A (SEL=1) or B (SEL=0).
// Latency: one cycle from acceptance to the element appearing on A or B.
// Backpressure: IN_READY tracks only the selected slot; a stalled slot never blocks the other.
// Ports:
//   CLK, RST                   - clock, async active-high reset
//   IN_VALID, IN_READY, DIN    - source handshake and element
//   SEL                        - destination select, sampled on the accepting edge only
//   A_VALID, A_READY, A        - destination A handshake and data (registered)
//   B_VALID, B_READY, B        - destination B handshake and data (registered)
//   BUSY                       - either destination holds an element
module deselect
  import ecc_pkg::*;
#(
  parameter int N = ECC_N
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] DIN,
  input  logic         SEL,
  output logic         A_VALID,
  input  logic         A_READY,
  output logic [N-1:0] A,
  output logic         B_VALID,
  input  logic         B_READY,
  output logic [N-1:0] B,
  output logic         BUSY
);

  logic w_accept;
  logic w_load_a;
  logic w_load_b;

  // Selected slot has room if it is empty or is draining this same edge
  assign IN_READY = SEL ? (!A_VALID || A_READY) : (!B_VALID || B_READY);
  assign w_accept = IN_VALID && IN_READY;
  assign w_load_a = w_accept && SEL;
  assign w_load_b = w_accept && !SEL;

  hold_slot #(.N(N)) u_slot_a (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_load_a),
    .din   (DIN),
    .valid (A_VALID),
    .ready (A_READY),
    .dout  (A)
  );

  hold_slot #(.N(N)) u_slot_b (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_load_b),
    .din   (DIN),
    .valid (B_VALID),
    .ready (B_READY),
    .dout  (B)
  );

  assign BUSY = A_VALID || B_VALID;

endmodule : deselect

// File: tb/tb_deselect.sv
module tb_deselect;

  localparam int N = 233;

  logic         CLK;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [N-1:0] DIN;
  logic         SEL;
  logic         A_VALID;
  logic         A_READY;
  logic [N-1:0] A;
  logic         B_VALID;
  logic         B_READY;
  logic [N-1:0] B;
  logic         BUSY;

  deselect #(.N(N)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .DIN      (DIN),
    .SEL      (SEL),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .A        (A),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY),
    .B        (B),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: each destination is a queue with capacity one element.
  // The data bus shows the most recently written element, which persists after a drain.
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  logic [N-1:0] last_a;
  logic [N-1:0] last_b;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_elem();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[N-1:0];
  endfunction

  function automatic logic model_room(input logic s, input logic ar, input logic br);
    if (s) return (qa.size() == 0) || ar;
    else   return (qb.size() == 0) || br;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".a_valid"}, N'(A_VALID), N'(qa.size() != 0));
    chk({tag, ".a"},       A,           (qa.size() != 0) ? qa[0] : last_a);
    chk({tag, ".b_valid"}, N'(B_VALID), N'(qb.size() != 0));
    chk({tag, ".b"},       B,           (qb.size() != 0) ? qb[0] : last_b);
    chk({tag, ".busy"},    N'(BUSY),    N'((qa.size() + qb.size()) != 0));
    chk({tag, ".in_ready"}, N'(IN_READY), N'(model_room(SEL, A_READY, B_READY)));
  endtask

  // Apply inputs just after an edge, check at the falling edge, then advance the model on the rising edge.
  task automatic step(input string tag, input logic v, input logic s, input logic [N-1:0] d,
                      input logic ar, input logic br);
    logic acc;
    logic pop_a;
    logic pop_b;
    IN_VALID = v; SEL = s; DIN = d; A_READY = ar; B_READY = br;
    @(negedge CLK);
    check_outputs(tag);
    acc   = v && model_room(s, ar, br);
    pop_a = (qa.size() != 0) && ar;
    pop_b = (qb.size() != 0) && br;
    @(posedge CLK);
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (acc && s)  begin qa.push_back(d); last_a = d; end
    if (acc && !s) begin qb.push_back(d); last_b = d; end
    #1;
  endtask

  int n_acc;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; SEL = 1'b0; DIN = '0; A_READY = 1'b0; B_READY = 1'b0;
    model_reset();

    // Reset state, including across a clock edge
    #2;
    check_outputs("reset");
    @(posedge CLK); #1;
    check_outputs("reset_edge");
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // Routing to A
    for (int i = 1; i <= 5; i++) step("route", 1'b1, 1'b1, N'(i), 1'b1, 1'b0);
    step("route_tail", 1'b0, 1'b1, '0, 1'b1, 1'b0);
    step("route_idle", 1'b0, 1'b1, '0, 1'b1, 1'b0);

    // Back-pressure on B
    step("bp_aa",     1'b1, 1'b0, N'(8'hAA), 1'b0, 1'b0);
    step("bp_bb",     1'b1, 1'b0, N'(8'hBB), 1'b0, 1'b0);
    step("bp_hold",   1'b1, 1'b0, N'(8'hBB), 1'b0, 1'b0);
    step("bp_swap",   1'b1, 1'b0, N'(8'hBB), 1'b0, 1'b1);
    step("bp_drain",  1'b0, 1'b0, '0,        1'b0, 1'b1);
    step("bp_empty",  1'b0, 1'b0, '0,        1'b0, 1'b1);

    // Throughput: 8 back-to-back elements into A
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      IN_VALID = 1'b1; SEL = 1'b1; A_READY = 1'b1;
      #1;
      n_acc += int'(IN_READY);
      step("thru", 1'b1, 1'b1, N'(32'h100 + i), 1'b1, 1'b0);
    end
    chk("thru_count", N'(n_acc), N'(8));
    step("thru_tail", 1'b0, 1'b1, '0, 1'b1, 1'b0);

    // Independence: A stalled full, B still accepts
    step("ind_fill_a", 1'b1, 1'b1, N'(8'h5A), 1'b0, 1'b0);
    step("ind_to_b",   1'b1, 1'b0, N'(8'h07), 1'b0, 1'b0);
    step("ind_check",  1'b0, 1'b0, '0,        1'b0, 1'b0);

    // SEL glitch while both slots are stalled; acceptance finally lands in A
    step("gl_1", 1'b1, 1'b1, N'(8'hC3), 1'b0, 1'b0);
    step("gl_0", 1'b1, 1'b0, N'(8'hC3), 1'b0, 1'b0);
    step("gl_1b", 1'b1, 1'b1, N'(8'hC3), 1'b0, 1'b0);
    step("gl_acc", 1'b1, 1'b1, N'(8'hC3), 1'b1, 1'b0);
    step("gl_land", 1'b0, 1'b1, '0, 1'b0, 1'b1);
    step("gl_drain", 1'b0, 1'b1, '0, 1'b1, 1'b1);

    // Reset mid-cycle with A full: outputs clear before any edge
    step("rst_fill", 1'b1, 1'b1, N'(8'h33), 1'b0, 1'b0);
    IN_VALID = 1'b0;
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge CLK); #1;
    check_outputs("rst_hold");
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    step("rst_nothing", 1'b0, 1'b1, '0, 1'b1, 1'b1);
    step("rst_first",   1'b1, 1'b0, N'(8'h44), 1'b0, 1'b0);
    step("rst_seen",    1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), rnd_elem(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_deselect
